ring_rr_arbiter: RTL and testbench

RING_RR_ARBITER -- requirements
Module: ring_rr_arbiter

---
 rtl/ring_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_ring_rr_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ring_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ring_rr_arbiter
//
// Round-robin arbiter for NUM_REQ requesters sharing one resource. A one-hot
// priority pointer walks from the MSB toward the LSB. The search for a winner
// starts at the pointer and moves downward, wrapping from bit 0 to the MSB.
// After a grant to index k the pointer moves to k-1, so the winner gets the
// lowest priority for the next arbitration.
//
// A grant is held until one of these happens:
//   - the owner releases the resource;
//   - the owner drops its request;
//   - the hold counter reaches MAX_HOLD. This case raises o_timeout.
// At least one idle cycle always separates two consecutive grants.
//
// Ports
//   i_clk          rising-edge clock
//   i_reset        synchronous active-high reset
//   i_req          per-requester level request
//   i_release      owner frees the resource (ignored while idle)
//   o_grant        one-hot grant, or all zero
//   o_grant_valid  high exactly when o_grant is nonzero
//   o_grant_id     index of the granted bit, 0 when idle
//   o_timeout      one-cycle pulse when the hold limit alone revoked a grant
// ----------------------------------------------------------------------------
module ring_rr_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic                       i_release,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic                       o_grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                       o_timeout
);

    localparam int         ID_W     = $clog2(NUM_REQ);
    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] ptr_q, ptr_d;
    logic [3:0]         hold_q, hold_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               valid_q, valid_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] req_lo;
    logic [NUM_REQ-1:0] search;
    logic [NUM_REQ-1:0] win_oh;
    logic [ID_W-1:0]    win_id;
    logic               owner_req;
    logic               rel_exit;
    logic               lim_exit;

    // The downward search from the pointer has two parts. First come the
    // requests at or below the pointer, highest index first. If none of
    // those is set, the search wraps to the whole vector, again highest
    // index first. ptr | (ptr - 1) is the mask of bits at or below the
    // one-hot pointer.
    always_comb begin
        req_lo = i_req & (ptr_q | (ptr_q - NUM_REQ'(1)));
        search = (|req_lo) ? req_lo : i_req;
        win_oh = '0;
        win_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (search[i]) begin
                win_oh = NUM_REQ'(1) << i;
                win_id = ID_W'(i);
            end
        end
    end

    assign owner_req = |(i_req & grant_q);
    assign rel_exit  = i_release || !owner_req;
    assign lim_exit  = (MAX_HOLD != 0) && (hold_q == HOLD_LIM);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        grant_d    = grant_q;
        valid_d    = valid_q;
        grant_id_d = grant_id_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                grant_d    = '0;
                valid_d    = 1'b0;
                grant_id_d = '0;
                if (|i_req) begin
                    state_d    = S_GRANT;
                    grant_d    = win_oh;
                    valid_d    = 1'b1;
                    grant_id_d = win_id;
                    hold_d     = 4'd1;
                    // Rotate the winner one place toward the LSB. A winner
                    // at bit 0 wraps the pointer to the MSB.
                    ptr_d      = {win_oh[0], win_oh[NUM_REQ-1:1]};
                end
            end
            S_GRANT: begin
                if (rel_exit || lim_exit) begin
                    state_d    = S_IDLE;
                    grant_d    = '0;
                    valid_d    = 1'b0;
                    grant_id_d = '0;
                    // A release in the same cycle as the hold limit counts
                    // as a normal release, not a timeout.
                    timeout_d  = lim_exit && !rel_exit;
                end else begin
                    hold_d = (hold_q == 4'hF) ? hold_q : hold_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= {1'b1, {(NUM_REQ-1){1'b0}}};
            hold_q     <= 4'd0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            grant_id_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            grant_id_q <= grant_id_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_grant       = grant_q;
    assign o_grant_valid = valid_q;
    assign o_grant_id    = grant_id_q;
    assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ring_rr_arbiter
//
// Three arbiters share the same inputs. They differ only in MAX_HOLD:
// 4, 15 (the default) and 0 (no limit). A behavioural model tracks each one
// as busy / owner index / pointer index / cycles held. The model searches
// with modular index arithmetic and is updated on every rising edge. All
// outputs are compared 1 time unit after that edge. Directed scenarios run
// first, followed by a randomized run with occasional resets.
// ----------------------------------------------------------------------------
module tb_ring_rr_arbiter;

    localparam int N  = 8;
    localparam int ND = 3;
    localparam int MH [ND] = '{4, 15, 0};

    logic         clk = 1'b0;
    logic         rst;
    logic         rel;
    logic [N-1:0] req;

    logic [N-1:0] grant [ND];
    logic         gv    [ND];
    logic [2:0]   gid   [ND];
    logic         tout  [ND];

    int n_checks = 0;
    int n_fail   = 0;

    int m_busy  [ND];
    int m_owner [ND];
    int m_ptr   [ND];
    int m_held  [ND];
    int m_tout  [ND];

    always #5 clk = ~clk;

    ring_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(4)) u_mh4 (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_release(rel),
        .o_grant(grant[0]), .o_grant_valid(gv[0]), .o_grant_id(gid[0]), .o_timeout(tout[0]));

    ring_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(15)) u_mh15 (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_release(rel),
        .o_grant(grant[1]), .o_grant_valid(gv[1]), .o_grant_id(gid[1]), .o_timeout(tout[1]));

    ring_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(0)) u_mh0 (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_release(rel),
        .o_grant(grant[2]), .o_grant_valid(gv[2]), .o_grant_id(gid[2]), .o_timeout(tout[2]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        m_busy[d]  = 0;
        m_owner[d] = 0;
        m_ptr[d]   = N - 1;
        m_held[d]  = 0;
        m_tout[d]  = 0;
    endtask

    task automatic model_step(input int d);
        int  j;
        bit  relx;
        bit  lim;
        if (rst) begin
            model_reset(d);
        end else if (m_busy[d] == 0) begin
            m_tout[d] = 0;
            for (int n = 0; n < N; n++) begin
                j = (m_ptr[d] - n + N) % N;
                if (m_busy[d] == 0 && req[j]) begin
                    m_busy[d]  = 1;
                    m_owner[d] = j;
                    m_held[d]  = 1;
                    m_ptr[d]   = (j + N - 1) % N;
                end
            end
        end else begin
            relx = rel || !req[m_owner[d]];
            lim  = (MH[d] != 0) && (m_held[d] == MH[d]);
            if (relx || lim) begin
                m_busy[d] = 0;
                m_tout[d] = (lim && !relx) ? 1 : 0;
            end else begin
                m_tout[d] = 0;
                if (m_held[d] < 15) m_held[d]++;
            end
        end
    endtask

    task automatic compare(input int d);
        logic [N-1:0] eg;
        eg = (m_busy[d] != 0) ? (N'(1) << m_owner[d]) : '0;
        check_val($sformatf("grant[%0d]", d), 32'(grant[d]), 32'(eg));
        check_val($sformatf("valid[%0d]", d), 32'(gv[d]), 32'(m_busy[d] != 0));
        check_val($sformatf("id[%0d]", d), 32'(gid[d]), (m_busy[d] != 0) ? m_owner[d] : 0);
        check_val($sformatf("timeout[%0d]", d), 32'(tout[d]), m_tout[d]);
        check_val($sformatf("onehot[%0d]", d), 32'($countones(grant[d]) <= 1), 32'd1);
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int d = 0; d < ND; d++) model_step(d);
        #1;
        for (int d = 0; d < ND; d++) compare(d);
    endtask

    initial begin
        int ids[$];
        int exp_fair [4] = '{7, 0, 7, 0};
        logic v_seq [6];
        logic t_seq [6];
        logic v_exp [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic t_exp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        for (int d = 0; d < ND; d++) model_reset(d);

        // Reset held two cycles with every request asserted
        rst = 1'b1; req = 8'hFF; rel = 1'b0;
        cycle();
        cycle();
        check_val("rst_grant", 32'(grant[0]), 32'h0);
        check_val("rst_valid", 32'(gv[0]), 32'h0);
        check_val("rst_id", 32'(gid[0]), 32'h0);
        rst = 1'b0;
        cycle();
        check_val("first_id_after_rst", 32'(gid[0]), 32'd7);
        check_val("first_valid_after_rst", 32'(gv[0]), 32'd1);

        // Fairness between bits 7 and 0, released every grant cycle
        rst = 1'b1; cycle();
        rst = 1'b0; req = 8'h81; rel = 1'b1;
        ids.delete();
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (gv[0]) ids.push_back(int'(gid[0]));
        end
        check_val("fair_count", ids.size(), 4);
        for (int i = 0; i < 4 && i < ids.size(); i++)
            check_val($sformatf("fair_id%0d", i), ids[i], exp_fair[i]);

        // Pointer wrap after the grant to bit 0
        req = 8'hA0;
        ids.delete();
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (gv[0]) ids.push_back(int'(gid[0]));
        end
        check_val("wrap_count", ids.size(), 2);
        if (ids.size() == 2) begin
            check_val("wrap_id0", ids[0], 7);
            check_val("wrap_id1", ids[1], 5);
        end
        rel = 1'b0;

        // Hold-limit timeout with a steady single request
        rst = 1'b1; cycle();
        rst = 1'b0; req = 8'h08;
        for (int c = 0; c < 6; c++) begin
            cycle();
            v_seq[c] = gv[0];
            t_seq[c] = tout[0];
        end
        for (int c = 0; c < 6; c++) begin
            check_val($sformatf("to_valid_c%0d", c), 32'(v_seq[c]), 32'(v_exp[c]));
            check_val($sformatf("to_pulse_c%0d", c), 32'(t_seq[c]), 32'(t_exp[c]));
        end
        check_val("to_regrant_id", 32'(gid[0]), 32'd3);

        // Release in the same cycle as the hold limit
        rst = 1'b1; cycle();
        rst = 1'b0; req = 8'h08;
        for (int c = 0; c < 4; c++) cycle();
        rel = 1'b1;
        cycle();
        check_val("coll_valid", 32'(gv[0]), 32'd0);
        check_val("coll_timeout", 32'(tout[0]), 32'd0);
        rel = 1'b0;

        // Reset in the middle of a grant
        rst = 1'b1; cycle();
        rst = 1'b0; req = 8'h04;
        cycle();
        check_val("mid_owner", 32'(gid[0]), 32'd2);
        req = 8'h84; rst = 1'b1;
        cycle();
        check_val("mid_rst_grant", 32'(grant[0]), 32'd0);
        check_val("mid_rst_timeout", 32'(tout[0]), 32'd0);
        rst = 1'b0;
        cycle();
        check_val("mid_rst_next_id", 32'(gid[0]), 32'd7);

        // Randomized traffic
        rst = 1'b1; cycle();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7, 0) == 0) req = N'($urandom);
            rel = ($urandom_range(9, 0) == 0);
            rst = ($urandom_range(149, 0) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
